// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with a fixed access latency,
// byte-lane masked stores and sign/zero-extended loads.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} stateT;

    stateT           stateQ, stateD;
    logic [3:0]      countQ, countD;
    logic            weQ, unsQ;
    logic [31:0]     addrQ, wdataQ;
    logic [1:0]      sizeQ;
    logic [31:0]     rdataQ, rdataD;
    logic            errQ, errD;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept, commit, fault, doWrite;
    logic [IdxW-1:0] memIdx;
    logic [31:0]     memWord, loadData, storeData;
    logic [3:0]      byteEn;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;

    assign req_ready = (stateQ == StIdle) && !rst;
    assign rsp_valid = (stateQ == StResp);
    assign rsp_rdata = rdataQ;
    assign rsp_err   = errQ;
    assign accept    = req_valid && req_ready;
    assign commit    = (stateQ == StBusy) && (countQ == 4'd0);
    assign memIdx    = addrQ[IdxW+1:2];
    assign memWord   = mem[memIdx];
    assign doWrite   = commit && weQ && !fault;

    always_comb begin
        fault = 1'b0;
        unique case (sizeQ)
            2'b00:   fault = 1'b0;
            2'b01:   fault = addrQ[0];
            2'b10:   fault = |addrQ[1:0];
            default: fault = 1'b1;
        endcase
        if ({2'b00, addrQ[31:2]} >= DEPTH_WORDS) fault = 1'b1;
    end

    // Lane selection: stores replicate the right-aligned data so the byte enables pick the lanes.
    always_comb begin
        loadByte  = 8'h00;
        unique case (addrQ[1:0])
            2'b00:   loadByte = memWord[7:0];
            2'b01:   loadByte = memWord[15:8];
            2'b10:   loadByte = memWord[23:16];
            default: loadByte = memWord[31:24];
        endcase
        loadHalf  = addrQ[1] ? memWord[31:16] : memWord[15:0];
        byteEn    = 4'b0000;
        storeData = wdataQ;
        loadData  = memWord;
        unique case (sizeQ)
            2'b00: begin
                byteEn    = 4'b0001 << addrQ[1:0];
                storeData = {4{wdataQ[7:0]}};
                loadData  = unsQ ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
            end
            2'b01: begin
                byteEn    = addrQ[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wdataQ[15:0]}};
                loadData  = unsQ ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = wdataQ;
                loadData  = memWord;
            end
        endcase
    end

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        rdataD = rdataQ;
        errD   = errQ;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    stateD = StBusy;
                    countD = 4'(LATENCY - 1);
                end
            end
            StBusy: begin
                if (countQ != 4'd0) begin
                    countD = countQ - 4'd1;
                end else begin
                    stateD = StResp;
                    errD   = fault;
                    rdataD = (fault || weQ) ? 32'h0 : loadData;
                end
            end
            StResp: begin
                if (rsp_ready) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            countQ <= 4'd0;
            rdataQ <= 32'h0;
            errQ   <= 1'b0;
            weQ    <= 1'b0;
            unsQ   <= 1'b0;
            addrQ  <= 32'h0;
            wdataQ <= 32'h0;
            sizeQ  <= 2'b00;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            rdataQ <= rdataD;
            errQ   <= errD;
            if (accept) begin
                weQ    <= req_we;
                unsQ   <= req_unsigned;
                addrQ  <= req_addr;
                wdataQ <= req_wdata;
                sizeQ  <= req_size;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[memIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses LATENCY=2, instance B uses LATENCY=3.
module tb_dmem_responder;
    logic        clk, rst, sel;
    logic        reqValid, reqWe, reqUns, rspReady;
    logic [31:0] reqAddr, reqWdata;
    logic [1:0]  reqSize;

    logic        aReqValid, aReqReady, aRspReady, aRspValid, aErr;
    logic        bReqValid, bReqReady, bRspReady, bRspValid, bErr;
    logic [31:0] aRdata, bRdata;
    logic        mReqReady, mRspValid, mErr;
    logic [31:0] mRdata;

    int nCmp = 0;
    int nFail = 0;

    assign aReqValid = reqValid && !sel;
    assign bReqValid = reqValid && sel;
    assign aRspReady = rspReady && !sel;
    assign bRspReady = rspReady && sel;
    assign mReqReady = sel ? bReqReady : aReqReady;
    assign mRspValid = sel ? bRspValid : aRspValid;
    assign mRdata    = sel ? bRdata : aRdata;
    assign mErr      = sel ? bErr : aErr;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dutA (
        .clk(clk), .rst(rst), .req_valid(aReqValid), .req_ready(aReqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_size(reqSize), .req_unsigned(reqUns),
        .rsp_valid(aRspValid), .rsp_ready(aRspReady), .rsp_rdata(aRdata), .rsp_err(aErr)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dutB (
        .clk(clk), .rst(rst), .req_valid(bReqValid), .req_ready(bReqReady), .req_we(reqWe),
        .req_addr(reqAddr), .req_wdata(reqWdata), .req_size(reqSize), .req_unsigned(reqUns),
        .rsp_valid(bRspValid), .rsp_ready(bRspReady), .rsp_rdata(bRdata), .rsp_err(bErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the selected instance; hold = cycles of response backpressure.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic [31:0] expData, input logic expErr, input int hold);
        int k;
        int expLat;
        expLat = sel ? 3 : 2;
        chk({tag, ".ready"}, {31'h0, mReqReady}, 32'h1);
        reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata;
        reqSize = size; reqUns = uns;
        @(posedge clk); #1;
        reqValid = 1'b0; reqWe = ~we; reqAddr = ~addr; reqWdata = ~wdata;
        reqSize = ~size; reqUns = ~uns;
        k = 0;
        while (!mRspValid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".lat"}, k, expLat);
        chk({tag, ".rdata"}, mRdata, expData);
        chk({tag, ".err"}, {31'h0, mErr}, {31'h0, expErr});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold.valid"}, {31'h0, mRspValid}, 32'h1);
            chk({tag, ".hold.rdata"}, mRdata, expData);
            chk({tag, ".hold.err"}, {31'h0, mErr}, {31'h0, expErr});
            chk({tag, ".hold.ready"}, {31'h0, mReqReady}, 32'h0);
        end
        rspReady = 1'b1;
        @(posedge clk); #1;
        rspReady = 1'b0;
        chk({tag, ".done.valid"}, {31'h0, mRspValid}, 32'h0);
        chk({tag, ".done.ready"}, {31'h0, mReqReady}, 32'h1);
        chk({tag, ".done.rdata"}, mRdata, expData);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; reqValid = 1'b0; reqWe = 1'b0; reqUns = 1'b0;
        rspReady = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0; reqSize = 2'b00;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst.readyA", {31'h0, aReqReady}, 32'h0);
        chk("rst.readyB", {31'h0, bReqReady}, 32'h0);
        chk("rst.validA", {31'h0, aRspValid}, 32'h0);
        chk("rst.rdataA", aRdata, 32'h0);
        chk("rst.errA", {31'h0, aErr}, 32'h0);
        rst = 1'b0; #1;
        chk("rel.readyA", {31'h0, aReqReady}, 32'h1);
        chk("rel.readyB", {31'h0, bReqReady}, 32'h1);
        @(posedge clk); #1;

        // Word store/load
        txn("stw10", 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 0);
        txn("ldw10", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 0);
        // Byte lane masking and extension
        txn("stw20", 1, 32'h20, 32'h11223344, 2'b10, 0, 32'h0, 0, 0);
        txn("stb22", 1, 32'h22, 32'h000000AA, 2'b00, 0, 32'h0, 0, 0);
        txn("ldw20", 0, 32'h20, 32'h0, 2'b10, 1, 32'h11AA3344, 0, 0);
        txn("ldb22s", 0, 32'h22, 32'h0, 2'b00, 0, 32'hFFFFFFAA, 0, 0);
        txn("ldb22u", 0, 32'h22, 32'h0, 2'b00, 1, 32'h000000AA, 0, 0);
        txn("ldb21s", 0, 32'h21, 32'h0, 2'b00, 0, 32'h00000033, 0, 0);
        // Half lanes
        txn("stw30", 1, 32'h30, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0, 0);
        txn("sth32", 1, 32'h32, 32'h00008001, 2'b01, 0, 32'h0, 0, 0);
        txn("ldh32s", 0, 32'h32, 32'h0, 2'b01, 0, 32'hFFFF8001, 0, 0);
        txn("ldh32u", 0, 32'h32, 32'h0, 2'b01, 1, 32'h00008001, 0, 0);
        txn("ldw30", 0, 32'h30, 32'h0, 2'b10, 0, 32'h8001F00D, 0, 0);
        txn("ldh30s", 0, 32'h30, 32'h0, 2'b01, 0, 32'hFFFFF00D, 0, 0);
        // Faults
        txn("stw40", 1, 32'h40, 32'h0BADC0DE, 2'b10, 0, 32'h0, 0, 0);
        txn("stw00", 1, 32'h00, 32'h13579BDF, 2'b10, 0, 32'h0, 0, 0);
        txn("f.ldw21", 0, 32'h21, 32'h0, 2'b10, 0, 32'h0, 1, 0);
        txn("f.sth43", 1, 32'h43, 32'h0000FFFF, 2'b01, 0, 32'h0, 1, 0);
        txn("f.size3", 1, 32'h20, 32'h00000000, 2'b11, 0, 32'h0, 1, 0);
        txn("f.oob", 1, 32'h1000, 32'hFFFFFFFF, 2'b10, 0, 32'h0, 1, 0);
        txn("f.ldoob", 0, 32'h1000, 32'h0, 2'b10, 0, 32'h0, 1, 0);
        txn("f.chk40", 0, 32'h40, 32'h0, 2'b10, 0, 32'h0BADC0DE, 0, 0);
        txn("f.chk20", 0, 32'h20, 32'h0, 2'b10, 0, 32'h11AA3344, 0, 0);
        txn("f.chk00", 0, 32'h00, 32'h0, 2'b10, 0, 32'h13579BDF, 0, 0);
        // Response backpressure
        txn("bp.ldw10", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 5);

        // Reset in the middle of a store on the LATENCY=3 instance
        sel = 1'b1;
        txn("b.stw40", 1, 32'h40, 32'h12345678, 2'b10, 0, 32'h0, 0, 0);
        reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h40; reqWdata = 32'h55;
        reqSize = 2'b10; reqUns = 1'b0;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("b.rst.valid", {31'h0, bRspValid}, 32'h0);
        chk("b.rst.ready", {31'h0, bReqReady}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b.rst2.valid", {31'h0, bRspValid}, 32'h0);
        chk("b.rst2.ready", {31'h0, bReqReady}, 32'h0);
        chk("b.rst2.rdata", bRdata, 32'h0);
        rst = 1'b0; #1;
        chk("b.rel.ready", {31'h0, bReqReady}, 32'h1);
        @(posedge clk); #1;
        txn("b.ldw40", 0, 32'h40, 32'h0, 2'b10, 0, 32'h12345678, 0, 0);
        sel = 1'b0; #1;
        txn("a.postrst", 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the load/store request interface that the memory stage drives.
- Accepts one request at a time over a valid/ready handshake and models a fixed multi-cycle access latency.
- Performs byte, half and word stores with lane masking, and byte, half and word loads with sign or zero extension.
- Returns read data or a write acknowledgement with an error flag over a second valid/ready handshake.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in storage; word index = req_addr[31:2]
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1=store, 0=load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  00=byte, 01=half, 10=word, 11=reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
rsp_valid  output  1  response present
rsp_ready  input  1  requester takes the response
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  request was faulted

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (asynchronous, rst=1): state=IDLE, count=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request fields cleared.
  - req_ready=0 while rst is high; req_ready=1 from the first cycle after rst is released.
  - Storage contents are not reset.
- req_ready = (state==IDLE) && !rst, generated combinationally. No request is accepted in BUSY or RESP, and requests are not queued.
- Accept on the clock edge where req_valid && req_ready:
  - latch we, addr, wdata, size, unsigned;
  - count <= LATENCY-1;
  - state <= BUSY.
- BUSY: if count != 0, decrement count. If count == 0, commit the access on this edge and go to RESP.
  - Result: a request accepted at edge N gives rsp_valid=1 after edge N+LATENCY.
- Fault check, performed at commit:
  - size==11, or
  - half with addr[0]!=0, or
  - word with addr[1:0]!=0, or
  - addr[31:2] >= DEPTH_WORDS.
  - On a fault: no storage write, rsp_rdata=0, rsp_err=1.
- Store commit:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - word writes all lanes;
  - other lanes of the word are unchanged;
  - rsp_rdata=0, rsp_err=0.
- Load commit:
  - byte selects lane addr[1:0]; half selects lanes addr[1]; word selects the whole word;
  - byte and half are extended to 32 bits per req_unsigned (word ignores it);
  - rsp_err=0.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready=1.
  - On the edge with rsp_valid && rsp_ready: state <= IDLE, rsp_valid <= 0. rsp_rdata and rsp_err keep their last values.
  - The next request can be accepted on the following edge (one IDLE cycle minimum between transactions).
- Reset mid-operation: a request in BUSY before its commit edge is dropped and its store is not performed. A response pending in RESP is discarded.
- Changes on the req_* inputs after acceptance have no effect on the transaction in progress.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word 0x10 (LATENCY=2) -> rsp_valid high exactly 2 cycles after each accept; load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
- After word 0x11223344 at 0x20: store byte 0xAA at 0x22, then load word 0x20 -> 0x11AA3344. Load byte 0x22 signed -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Store half 0x8001 at 0x32, then load half 0x32 signed -> 0xFFFF8001; unsigned -> 0x00008001. Load word 0x30 shows the upper lanes = 0x8001 and the lower lanes unchanged.
- Faults: load word 0x21, store half 0x43, size=11, addr 0x1000 with DEPTH_WORDS=1024 -> rsp_err=1, rsp_rdata=0 for each. A subsequent load shows the target words unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout. Raising rsp_ready gives IDLE next edge and req_ready=1.
- Assert rst one cycle after accepting a store of 0x55 to word 0x40 (LATENCY=3), then load word 0x40 -> old value returned (store never performed). During rst: rsp_valid=0, req_ready=0.
